// File: rtl/gate_bist_pkg.sv
// Shared definitions for the gate BIST checker: FSM encoding, vector count
// and truth tables for common 2-input gates, indexed by {a,b}.
package gate_bist_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam int unsigned NUM_VEC = 4;

    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_XOR  = 4'b0110;

endpackage

// File: rtl/gate_bist_checker_settle_timer.sv
// Loadable 4-bit down-counter with a zero flag; it holds at zero rather than
// wrapping, so a stray decrement can never rearm the settle window.
module settle_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       dec,
    input  logic [3:0] load_val,
    output logic       zero
);

    logic [3:0] count_q;
    logic [3:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != 4'd0)) begin
            count_d = count_q - 4'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == 4'd0);

endmodule

// File: rtl/gate_bist_checker.sv
// Exhaustive 2-input gate tester: drives each {a,b} vector, waits SETTLE
// cycles, samples the gate output and records mismatches against EXPECTED.
module gate_bist_checker
    import gate_bist_pkg::*;
#(
    parameter logic [3:0]  EXPECTED = TT_NOR,
    parameter int unsigned SETTLE   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic       dut_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_vec
);

    localparam logic [3:0] SETTLE_RELOAD = 4'(SETTLE - 1);
    localparam logic [1:0] LAST_IDX      = 2'(NUM_VEC - 1);

    state_e     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [2:0] err_q, err_d;
    logic [3:0] fail_q, fail_d;
    logic       tmr_load, tmr_dec, tmr_zero;

    settle_timer u_settle_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .dec      (tmr_dec),
        .load_val (SETTLE_RELOAD),
        .zero     (tmr_zero)
    );

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        err_d    = err_q;
        fail_d   = fail_q;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = DRIVE;
                    idx_d    = 2'd0;
                    err_d    = 3'd0;
                    fail_d   = 4'd0;
                    tmr_load = 1'b1;
                end
            end
            DRIVE: begin
                if (tmr_zero) begin
                    state_d = SAMPLE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            SAMPLE: begin
                if (dut_out != EXPECTED[idx_q]) begin
                    fail_d[idx_q] = 1'b1;
                    err_d         = err_q + 3'd1;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d    = idx_q + 2'd1;
                    tmr_load = 1'b1;
                    state_d  = DRIVE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            err_q   <= 3'd0;
            fail_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
        end
    end

    // The vector index register drives the gate directly; it sits at 3 in DONE.
    assign a         = idx_q[1];
    assign b         = idx_q[0];
    assign busy      = (state_q == DRIVE) || (state_q == SAMPLE);
    assign done      = (state_q == DONE);
    assign pass      = (state_q == DONE) && (err_q == 3'd0);
    assign err_count = err_q;
    assign fail_vec  = fail_q;

endmodule

// File: tb/tb_gate_bist_checker.sv
// Bench for gate_bist_checker: a cycle-level reference model checked every
// cycle, plus directed runs with hand-computed latencies and results.
module tb_gate_bist_checker;

    localparam int S = 4;
    localparam logic [3:0] EXP_TT = 4'b0001;

    logic       clk, rst, start;
    logic       a, b, dut_out, busy, done, pass;
    logic [2:0] err_count;
    logic [3:0] fail_vec;

    logic       start1, a1, b1, dut_out1, busy1, done1, pass1;
    logic [2:0] err_count1;
    logic [3:0] fail_vec1;

    int checks = 0;
    int failures = 0;
    int gate_mode = 0;   // 0: NOR, 1: stuck at 0, 2: OR

    gate_bist_checker #(.EXPECTED(EXP_TT), .SETTLE(S)) u_dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .dut_out(dut_out),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count), .fail_vec(fail_vec)
    );

    gate_bist_checker #(.EXPECTED(EXP_TT), .SETTLE(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .dut_out(dut_out1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err_count1), .fail_vec(fail_vec1)
    );

    function automatic logic gate_fn(input int mode, input logic ga, input logic gb);
        case (mode)
            1:       return 1'b0;
            2:       return ga | gb;
            default: return ~(ga | gb);
        endcase
    endfunction

    assign dut_out  = gate_fn(gate_mode, a, b);
    assign dut_out1 = ~(a1 | b1);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: elapsed cycles since start determine vector and phase.
    int         m_t = 0;
    int         m_err = 0;
    bit         m_run = 0;
    bit         m_done = 0;
    logic [3:0] m_fail = 4'd0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run = 0; m_done = 0; m_t = 0; m_err = 0; m_fail = 4'd0;
        end else if (!m_run) begin
            if (start) begin
                m_run = 1; m_done = 0; m_t = 0; m_err = 0; m_fail = 4'd0;
            end
        end else begin
            if (m_t % (S + 1) == S) begin
                int v;
                logic [1:0] vv;
                v  = m_t / (S + 1);
                vv = 2'(v);
                if (gate_fn(gate_mode, vv[1], vv[0]) != EXP_TT[v]) begin
                    m_err++;
                    m_fail[v] = 1'b1;
                end
            end
            m_t++;
            if (m_t == 4 * (S + 1)) begin
                m_run = 0;
                m_done = 1;
            end
        end
    end

    always @(negedge clk) begin
        int exp_ab;
        exp_ab = m_run ? (m_t / (S + 1)) : (m_done ? 3 : 0);
        check("model_ab",   {30'd0, a, b}, 32'(exp_ab));
        check("model_busy", {31'd0, busy}, {31'd0, m_run});
        check("model_done", {31'd0, done}, {31'd0, m_done});
        check("model_pass", {31'd0, pass}, {31'd0, (m_done && m_err == 0)});
        check("model_err",  {29'd0, err_count}, 32'(m_err));
        check("model_fail", {28'd0, fail_vec}, {28'd0, m_fail});
    end

    // Called at the negedge after the start edge; returns edges until done.
    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_zero(input string name);
        check({name, "_ab"},   {30'd0, a, b}, 32'd0);
        check({name, "_busy"}, {31'd0, busy}, 32'd0);
        check({name, "_done"}, {31'd0, done}, 32'd0);
        check({name, "_pass"}, {31'd0, pass}, 32'd0);
        check({name, "_err"},  {29'd0, err_count}, 32'd0);
        check({name, "_fail"}, {28'd0, fail_vec}, 32'd0);
    endtask

    initial begin
        int lat;
        rst = 1'b1; start = 1'b0; start1 = 1'b0;
        #3;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("idle");

        // NOR gate attached: clean pass, 20-cycle latency.
        pulse_start();
        wait_done(lat);
        check("nor_latency", 32'(lat), 32'd20);
        check("nor_pass", {31'd0, pass}, 32'd1);
        check("nor_err",  {29'd0, err_count}, 32'd0);
        check("nor_fail", {28'd0, fail_vec}, 32'h0);
        check("nor_ab",   {30'd0, a, b}, 32'd3);

        // Output stuck at 0: only vector 00 (expects 1) mismatches.
        repeat (2) @(negedge clk);
        gate_mode = 1;
        pulse_start();
        check("restart_done_low", {31'd0, done}, 32'd0);
        wait_done(lat);
        check("stuck_latency", 32'(lat), 32'd20);
        check("stuck_pass", {31'd0, pass}, 32'd0);
        check("stuck_err",  {29'd0, err_count}, 32'd1);
        check("stuck_fail", {28'd0, fail_vec}, 32'b0001);

        // OR gate against NOR table: every vector mismatches.
        gate_mode = 2;
        pulse_start();
        wait_done(lat);
        check("or_pass", {31'd0, pass}, 32'd0);
        check("or_err",  {29'd0, err_count}, 32'd4);
        check("or_fail", {28'd0, fail_vec}, 32'b1111);

        // Reset mid-run clears everything immediately; fresh run afterwards.
        gate_mode = 0;
        pulse_start();
        repeat (8) @(negedge clk);
        #1 rst = 1'b1;
        #1 check_zero("midrun_rst");
        @(negedge clk);
        rst = 1'b0;
        pulse_start();
        wait_done(lat);
        check("post_rst_latency", 32'(lat), 32'd20);
        check("post_rst_pass", {31'd0, pass}, 32'd1);

        // start held high: no mid-run restart, then restart from DONE.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        wait_done(lat);
        check("held_latency", 32'(lat), 32'd20);
        check("held_done", {31'd0, done}, 32'd1);
        @(negedge clk);
        check("held_restart_done", {31'd0, done}, 32'd0);
        check("held_restart_busy", {31'd0, busy}, 32'd1);
        start = 1'b0;
        @(negedge clk);
        wait_done(lat);
        check("held_second_pass", {31'd0, pass}, 32'd1);

        // SETTLE=1 instance: 4*(1+1) = 8 cycles.
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        lat = 0;
        while (!done1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("s1_latency", 32'(lat), 32'd8);
        check("s1_pass", {31'd0, pass1}, 32'd1);
        check("s1_err",  {29'd0, err_count1}, 32'd0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
